alu_issue_decoder: RTL

- Decode/issue stage that drives the integer ALU's operand interface (ALU_op, val1, val2) for one RV32I instruction stream.
- Accepts fetched instructions over a valid/ready handshake and decodes the OP, OP-IMM, LUI and AUIPC opcodes.
- Reads rs1/rs2 from the register file and registers a decoded ALU operation plus writeback info in a single-entry output buffer.
- Provides flush, illegal-instruction flagging and a running issue counter.

---
 rtl/alu_issue_decoder.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_decoder.sv
// RV32I decode/issue stage for the integer ALU: OP, OP-IMM, LUI, AUIPC.
// Single-entry registered output buffer with valid/ready, flush and issue counter.
module alu_issue_decoder #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    output logic [4:0]       rs1_addr,
    output logic [4:0]       rs2_addr,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       ALU_op,
    output logic [XLEN-1:0]  val1,
    output logic [XLEN-1:0]  val2,
    output logic [4:0]       rd,
    output logic             wb_en,
    output logic             illegal,
    output logic [CNT_W-1:0] issue_count
);

    localparam logic [3:0] OP_NONE = 4'b0000;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_LTU  = 4'b1000;
    localparam logic [3:0] OP_LT   = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [6:0]      opcode;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic            is_op;
    logic            is_imm;
    logic            is_lui;
    logic            is_auipc;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [3:0]      base_op;
    logic [3:0]      d_op;
    logic [XLEN-1:0] d_v1;
    logic [XLEN-1:0] d_v2;
    logic            d_ill;
    logic            d_wb;
    logic            accept;
    logic            out_hs;

    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    assign is_op    = (opcode == OPC_OP);
    assign is_imm   = (opcode == OPC_IMM);
    assign is_lui   = (opcode == OPC_LUI);
    assign is_auipc = (opcode == OPC_AUIPC);

    assign imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign imm_u = {in_instr[31:12], {(XLEN-20){1'b0}}};

    assign in_ready = rst_n & ~flush & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;
    assign out_hs   = out_valid & out_ready;

    always_comb begin
        base_op = OP_ADD;
        unique case (funct3)
            3'b000: base_op = OP_ADD;
            3'b001: base_op = OP_SLL;
            3'b010: base_op = OP_LT;
            3'b011: base_op = OP_LTU;
            3'b100: base_op = OP_XOR;
            3'b101: base_op = OP_SRL;
            3'b110: base_op = OP_OR;
            3'b111: base_op = OP_AND;
        endcase
    end

    always_comb begin
        d_op  = OP_NONE;
        d_v1  = '0;
        d_v2  = '0;
        d_ill = 1'b0;
        unique case (1'b1)
            is_op: begin
                d_v1 = rs1_data;
                d_v2 = rs2_data;
                if (funct7 == F7_ZERO)
                    d_op = base_op;
                else if (funct7 == F7_ALT && funct3 == 3'b000)
                    d_op = OP_SUB;
                else if (funct7 == F7_ALT && funct3 == 3'b101)
                    d_op = OP_SRA;
                else
                    d_ill = 1'b1;
            end
            is_imm: begin
                d_v1 = rs1_data;
                d_v2 = imm_i;
                d_op = base_op;
                if (funct3 == 3'b001 && funct7 != F7_ZERO)
                    d_ill = 1'b1;
                if (funct3 == 3'b101) begin
                    if (funct7 == F7_ALT)
                        d_op = OP_SRA;
                    else if (funct7 != F7_ZERO)
                        d_ill = 1'b1;
                end
            end
            is_lui: begin
                d_op = OP_ADD;
                d_v2 = imm_u;
            end
            is_auipc: begin
                d_op = OP_ADD;
                d_v1 = in_pc;
                d_v2 = imm_u;
            end
            default: d_ill = 1'b1;
        endcase
        // the ALU shifts by the whole operand, so keep only the shamt
        if (d_op == OP_SLL || d_op == OP_SRL || d_op == OP_SRA)
            d_v2 = {{(XLEN-5){1'b0}}, d_v2[4:0]};
        if (d_ill) begin
            d_op = OP_NONE;
            d_v1 = '0;
            d_v2 = '0;
        end
    end

    assign d_wb = ~d_ill & (in_instr[11:7] != 5'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            ALU_op      <= OP_NONE;
            val1        <= '0;
            val2        <= '0;
            rd          <= '0;
            wb_en       <= 1'b0;
            illegal     <= 1'b0;
            issue_count <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else begin
            if (out_hs)
                issue_count <= issue_count + CNT_ONE;
            if (accept) begin
                out_valid <= 1'b1;
                ALU_op    <= d_op;
                val1      <= d_v1;
                val2      <= d_v2;
                rd        <= in_instr[11:7];
                wb_en     <= d_wb;
                illegal   <= d_ill;
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
